// File: rtl/alu_seq_ctrl_if.sv
// Handshake bundle between the command source and the ALU operation sequencer.
// master = command source / datapath side, slave = sequencer.
interface alu_seq_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 4
);
  logic              start;
  logic [OP_W-1:0]   op_in;
  logic [DATA_W-1:0] bus_in;
  logic              bus_valid;
  logic              alu_done;
  logic              ld_a;
  logic              ld_b;
  logic [OP_W-1:0]   op_out;
  logic              alu_start;
  logic              ld_r;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, op_in, bus_in, bus_valid, alu_done,
    input  ld_a, ld_b, op_out, alu_start, ld_r, busy, done, err
  );

  modport slave (
    input  start, op_in, bus_in, bus_valid, alu_done,
    output ld_a, ld_b, op_out, alu_start, ld_r, busy, done, err
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// ALU operation sequencer: latch opcode, steer A then B from the shared bus,
// start the ALU, wait (bounded) for completion, then load the result and report.
module alu_seq_ctrl #(
  parameter int DATA_W  = 8,
  parameter int OP_W    = 4,
  parameter int TIMEOUT = 255
) (
  input logic           clk,
  input logic           rst,
  alu_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_GET_A, S_GET_B, S_EXEC, S_WAIT, S_DONE
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t          state, state_nx;
  logic [OP_W-1:0] op_q;
  logic [7:0]      cnt;
  logic            err_q;

  // Operands go straight from the bus to the register bank; nothing is stored here.
  logic [DATA_W-1:0] bus_in_unused;
  assign bus_in_unused = bus.bus_in;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q  <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (bus.start) op_q <= bus.op_in;
        S_EXEC: cnt <= '0;
        S_WAIT: begin
          // alu_done takes priority over an expiring count in the last WAIT cycle
          if (bus.alu_done)       err_q <= 1'b0;
          else if (cnt == CNT_LAST) err_q <= 1'b1;
          else                    cnt   <= cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (bus.start)     state_nx = S_GET_A;
      S_GET_A: if (bus.bus_valid) state_nx = S_GET_B;
      S_GET_B: if (bus.bus_valid) state_nx = S_EXEC;
      S_EXEC:  state_nx = S_WAIT;
      S_WAIT:  if (bus.alu_done || cnt == CNT_LAST) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Everything is held low while rst is asserted, Mealy enables included.
  always_comb begin
    bus.ld_a      = 1'b0;
    bus.ld_b      = 1'b0;
    bus.alu_start = 1'b0;
    bus.ld_r      = 1'b0;
    bus.done      = 1'b0;
    bus.err       = 1'b0;
    bus.busy      = 1'b0;
    bus.op_out    = '0;
    if (!rst) begin
      bus.busy   = (state != S_IDLE);
      bus.op_out = op_q;
      case (state)
        S_GET_A: bus.ld_a      = bus.bus_valid;
        S_GET_B: bus.ld_b      = bus.bus_valid;
        S_EXEC:  bus.alu_start = 1'b1;
        S_WAIT:  bus.ld_r      = bus.alu_done;
        S_DONE: begin
          bus.done = 1'b1;
          bus.err  = err_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl: stimulus queues expected output pulses with
// their cycle numbers; a negedge monitor pops and compares every pulse it sees.
module tb_alu_seq_ctrl;
  localparam int DW = 8;
  localparam int OW = 4;
  localparam int TO = 4;

  // flags: {ld_a, ld_b, alu_start, ld_r, done, err, busy}
  localparam logic [6:0] EV_LA = 7'b1000001;
  localparam logic [6:0] EV_LB = 7'b0100001;
  localparam logic [6:0] EV_AS = 7'b0010001;
  localparam logic [6:0] EV_LR = 7'b0001001;
  localparam logic [6:0] EV_DN = 7'b0000101;
  localparam logic [6:0] EV_DE = 7'b0000111;

  typedef struct {
    int          c;
    logic [10:0] s;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  ev_t  exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_seq_ctrl_if #(.DATA_W(DW), .OP_W(OW)) bus ();

  alu_seq_ctrl #(.DATA_W(DW), .OP_W(OW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [6:0] f, input logic [3:0] op);
    ev_t e;
    e.c = c;
    e.s = {f, op};
    exp_q.push_back(e);
  endtask

  task automatic drv(input logic st, input logic [3:0] op, input logic bv,
                     input logic [7:0] bi, input logic ad);
    bus.start     = st;
    bus.op_in     = op;
    bus.bus_valid = bv;
    bus.bus_in    = bi;
    bus.alu_done  = ad;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic peek_busy(input string nm, input logic exp);
    @(negedge clk);
    chk(nm, 32'(bus.busy), 32'(exp));
  endtask

  function automatic logic [10:0] all_outs();
    return {bus.ld_a, bus.ld_b, bus.alu_start, bus.ld_r, bus.done, bus.err,
            bus.busy, bus.op_out};
  endfunction

  // Monitor: every cycle with any output pulse must match the next expected event.
  always @(negedge clk) begin : mon
    logic [10:0] act;
    ev_t e;
    if (bus.ld_a | bus.ld_b | bus.alu_start | bus.ld_r | bus.done | bus.err) begin
      act = all_outs();
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 32'(act), 32'h0);
      end else begin
        e = exp_q.pop_front();
        chk("ev_cycle", 32'(cyc), 32'(e.c));
        chk("ev_outputs", 32'(act), 32'(e.s));
      end
    end
  end

  // Zero-wait transaction; op_in is scrambled after acceptance to prove latching.
  task automatic nominal(input logic [3:0] op);
    int n;
    n = cyc;
    push(n+1, EV_LA, op); push(n+2, EV_LB, op); push(n+3, EV_AS, op);
    push(n+4, EV_LR, op); push(n+5, EV_DN, op);
    drv(1, op, 1, 8'h11, 0); peek_busy("nom_busy_idle", 0); adv();
    drv(0, ~op, 1, 8'hA5, 0); adv();
    drv(0, ~op, 1, 8'h3C, 0); adv();
    drv(0, ~op, 0, 8'h00, 0); adv();
    drv(0, ~op, 0, 8'h00, 1); adv();
    drv(0, ~op, 0, 8'h00, 0); adv();
  endtask

  initial begin : wdog
    #200000;
    $display("FAIL watchdog: actual no finish required finish by 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    drv(1, 4'hF, 1, 8'hFF, 1);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_outputs", 32'(all_outs()), 32'h0);
      adv();
    end
    rst = 1'b0;
    drv(0, 4'h0, 0, 8'h00, 0);
    @(negedge clk);
    chk("post_rst_busy", 32'(bus.busy), 32'h0);
    chk("post_rst_op", 32'(bus.op_out), 32'h0);
    adv();

    nominal(4'h3);

    // Bus stalls: 2 idle cycles before A, 1 before B; alu_done in GET_A ignored.
    n = cyc;
    push(n+3, EV_LA, 4'h5); push(n+5, EV_LB, 4'h5); push(n+6, EV_AS, 4'h5);
    push(n+7, EV_LR, 4'h5); push(n+8, EV_DN, 4'h5);
    drv(1, 4'h5, 0, 8'h00, 0); peek_busy("stall_busy_idle", 0); adv();
    drv(0, 4'h0, 0, 8'h00, 1); adv();
    drv(0, 4'h0, 0, 8'h00, 0); adv();
    drv(0, 4'h0, 1, 8'hA5, 0); adv();
    drv(0, 4'h0, 0, 8'h00, 0); adv();
    drv(0, 4'h0, 1, 8'h3C, 0); adv();
    drv(0, 4'h0, 1, 8'h00, 0); adv();
    drv(0, 4'h0, 0, 8'h00, 1); adv();
    drv(0, 4'h0, 0, 8'h00, 0); adv();

    // Timeout with no alu_done; stray starts in GET_B, WAIT and DONE.
    n = cyc;
    push(n+1, EV_LA, 4'h9); push(n+2, EV_LB, 4'h9); push(n+3, EV_AS, 4'h9);
    push(n+8, EV_DE, 4'h9);
    drv(1, 4'h9, 0, 8'h00, 0); peek_busy("to_busy_idle", 0); adv();
    drv(0, 4'h0, 1, 8'h12, 0); adv();
    drv(1, 4'h2, 1, 8'h34, 0); adv();
    drv(0, 4'h0, 0, 8'h00, 0); adv();
    drv(0, 4'h0, 0, 8'h00, 0); peek_busy("to_busy_wait", 1); adv();
    drv(1, 4'h7, 0, 8'h00, 0); adv();
    drv(0, 4'h0, 0, 8'h00, 0); adv();
    drv(0, 4'h0, 0, 8'h00, 0); adv();
    drv(1, 4'h8, 0, 8'h00, 0); adv();
    drv(0, 4'h0, 0, 8'h00, 0); peek_busy("to_idle_1", 0); adv();
    drv(0, 4'h0, 0, 8'h00, 0); peek_busy("to_idle_2", 0);
    @(negedge clk);
    chk("to_op_hold", 32'(bus.op_out), 32'h9);
    adv();

    // alu_done in the last WAIT cycle wins over the timeout.
    n = cyc;
    push(n+1, EV_LA, 4'hA); push(n+2, EV_LB, 4'hA); push(n+3, EV_AS, 4'hA);
    push(n+7, EV_LR, 4'hA); push(n+8, EV_DN, 4'hA);
    drv(1, 4'hA, 0, 8'h00, 0); adv();
    drv(0, 4'h0, 1, 8'h01, 0); adv();
    drv(0, 4'h0, 1, 8'h02, 0); adv();
    drv(0, 4'h0, 0, 8'h00, 0); adv();
    drv(0, 4'h0, 0, 8'h00, 0); adv();
    drv(0, 4'h0, 0, 8'h00, 0); adv();
    drv(0, 4'h0, 0, 8'h00, 0); adv();
    drv(0, 4'h0, 0, 8'h00, 1); adv();
    drv(0, 4'h0, 0, 8'h00, 0); adv();

    // Reset in the middle of WAIT: no ld_r, no done, back to IDLE with op_out cleared.
    n = cyc;
    push(n+1, EV_LA, 4'h6); push(n+2, EV_LB, 4'h6); push(n+3, EV_AS, 4'h6);
    drv(1, 4'h6, 0, 8'h00, 0); adv();
    drv(0, 4'h0, 1, 8'h01, 0); adv();
    drv(0, 4'h0, 1, 8'h02, 0); adv();
    drv(0, 4'h0, 0, 8'h00, 0); adv();
    drv(0, 4'h0, 0, 8'h00, 0); adv();
    rst = 1'b1;
    drv(1, 4'h0, 1, 8'h00, 1);
    @(negedge clk);
    chk("midrst_outputs", 32'(all_outs()), 32'h0);
    adv();
    rst = 1'b0;
    drv(0, 4'h0, 0, 8'h00, 0);
    @(negedge clk);
    chk("midrst_busy", 32'(bus.busy), 32'h0);
    chk("midrst_op", 32'(bus.op_out), 32'h0);
    adv();

    nominal(4'hC);

    drv(0, 4'h0, 0, 8'h00, 0);
    repeat (4) adv();
    chk("sb_drain", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Operation sequencer for the 8-bit ALU datapath. It accepts an operation request, steers operands from a shared 8-bit bus into the A and B operand registers, starts the ALU, and waits for completion with a bounded timeout. It then pulses the result-register load enable and reports completion. It sits between the command source and the operand/result register bank built from the team's flip-flop cells.

## Interface
- `DATA_W`, default 8: operand bus width (documents bus_in width; no internal data storage)
- `OP_W`, default 4: opcode width
- `TIMEOUT`, default 255: maximum WAIT cycles before abort; legal range 1..255
- `clk`, in, 1: single clock; all state changes on the rising edge
- `rst`, in, 1: reset, synchronous and active-high
- `start`, in, 1: operation request; sampled only in IDLE
- `op_in`, in, OP_W: opcode; captured in the cycle start is accepted
- `bus_in`, in, DATA_W: shared operand bus; wired to the A and B register D inputs externally
- `bus_valid`, in, 1: bus_in carries a valid operand this cycle
- `alu_done`, in, 1: ALU completion strobe
- `ld_a`, out, 1: load enable for operand register A
- `ld_b`, out, 1: load enable for operand register B
- `op_out`, out, OP_W: latched opcode presented to the ALU
- `alu_start`, out, 1: one-cycle ALU start pulse
- `ld_r`, out, 1: one-cycle result-register load enable
- `busy`, out, 1: high in every state except IDLE
- `done`, out, 1: one-cycle completion pulse
- `err`, out, 1: one-cycle timeout flag, asserted only together with done

## Operation
- States: IDLE, GET_A, GET_B, EXEC, WAIT, DONE. An 8-bit wait counter `cnt` runs alongside the state.
- IDLE:
  - start=1 → GET_A; op_out <= op_in.
  - Otherwise stay in IDLE.
- GET_A:
  - ld_a = bus_valid (Mealy output).
  - bus_valid=1 → GET_B; otherwise stay.
- GET_B:
  - ld_b = bus_valid (Mealy output).
  - bus_valid=1 → EXEC; otherwise stay.
- EXEC:
  - alu_start=1 (Moore output); cnt <= 0.
  - Always → WAIT.
- WAIT:
  - ld_r = alu_done (Mealy output).
  - alu_done=1 → DONE with err_q <= 0.
  - Otherwise, if cnt == TIMEOUT-1 → DONE with err_q <= 1.
  - Otherwise cnt <= cnt+1.
- DONE:
  - done=1, err=err_q.
  - Always → IDLE.
- op_out holds its value from acceptance until the next accepted start.
- Inputs outside their sampling state are ignored:
  - start outside IDLE, including in DONE;
  - bus_valid outside GET_A/GET_B;
  - alu_done outside WAIT.
- The ALU result is never captured on timeout: ld_r stays 0.

## Timing
- Reset:
  - While rst=1, all outputs are forced to 0, including the Mealy enables.
  - After the rst edge: state IDLE, op_out=0, cnt=0, err_q=0.
- Reset mid-operation: IDLE at the next edge. No done pulse and no further ld_a, ld_b, ld_r or alu_start.
- Zero-wait request timeline (start accepted in cycle N):
  - bus_valid is ignored in cycle N.
  - Earliest ld_a is N+1; earliest ld_b is N+2.
  - alu_start is N+3.
  - Earliest alu_done/ld_r is N+4; done is N+5.
  - IDLE at N+6; the earliest next start is accepted at N+6.
- Bus stalls: each cycle of bus_valid=0 in GET_A or GET_B adds one cycle of latency.
- WAIT lasts at most TIMEOUT cycles.
  - alu_done in the final WAIT cycle wins: ld_r=1 and err=0.
- Each transaction produces exactly one alu_start pulse and exactly one done pulse.
- busy is registered from state: high from cycle N+1 through the DONE cycle.

## Test plan
- Reset: with rst=1 held 3 cycles, drive start=1 and bus_valid=1 → all outputs 0. After release, busy=0 and op_out=0.
- Nominal transaction:
  - Stimulus: start with op_in=4'h3; bus_valid with 8'hA5 at N+1 and 8'h3C at N+2; alu_done at N+4.
  - Required: ld_a@N+1, ld_b@N+2, alu_start@N+3, ld_r@N+4, done@N+5 with err=0, op_out=4'h3 throughout, busy N+1..N+5.
- Bus stall: bus_valid low for 2 cycles before A and 1 cycle before B → done at N+8; ld_a and ld_b each a single-cycle pulse.
- Timeout, with TIMEOUT=4 and no alu_done:
  - WAIT occupies N+4..N+7; done=1 and err=1 at N+8; ld_r never asserted.
  - Repeat with alu_done at N+7 → ld_r@N+7, err=0.
- Ignored inputs:
  - start pulses during GET_B, WAIT and DONE produce no second transaction, and op_out is unchanged.
  - alu_done in GET_A produces no ld_r.
- Reset mid-WAIT: rst=1 at N+5 → no done pulse; IDLE afterwards; a new start is accepted normally.
